// File: rtl/block_shuffle_pipe_if.sv
// block_shuffle_pipe_if: valid/ready stream carrying a data block and its shuffle-mode bit
interface block_shuffle_pipe_if #(
    parameter int DATA_W = 64
) ();
    logic              valid;
    logic              ready;
    logic              inv;
    logic [DATA_W-1:0] data;

    modport master (output valid, data, inv, input ready);
    modport slave  (input valid, data, inv, output ready);
endinterface

// File: rtl/block_shuffle_pipe.sv
// block_shuffle_pipe: per-word lane rotation (forward/inverse) feeding an elastic valid/ready pipeline
module block_shuffle_pipe #(
    parameter int DATA_W = 64,
    parameter int WORD_W = 16,
    parameter int LANE_W = 4,
    parameter int SHIFT  = 2,
    parameter int STAGES = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    block_shuffle_pipe_if.slave          src,
    block_shuffle_pipe_if.master         dst,
    output logic [$clog2(STAGES+1)-1:0]  count_o
);
    localparam int NW = DATA_W / WORD_W;
    localparam int NL = WORD_W / LANE_W;
    localparam int R  = SHIFT * LANE_W;
    localparam int CW = $clog2(STAGES + 1);

    if (LANE_W < 1 || WORD_W < LANE_W || WORD_W % LANE_W != 0) begin : g_bad_lane
        $error("block_shuffle_pipe: WORD_W must be a positive multiple of LANE_W");
    end
    if (DATA_W < WORD_W || DATA_W % WORD_W != 0) begin : g_bad_word
        $error("block_shuffle_pipe: DATA_W must be a positive multiple of WORD_W");
    end
    if (SHIFT < 0 || SHIFT >= NL) begin : g_bad_shift
        $error("block_shuffle_pipe: SHIFT must lie in 0 .. WORD_W/LANE_W-1");
    end
    if (STAGES < 1) begin : g_bad_stages
        $error("block_shuffle_pipe: STAGES must be at least 1");
    end

    logic [DATA_W-1:0] shuf;
    logic [WORD_W-1:0] w;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] mode;
    logic [STAGES-1:0] ld;
    logic [DATA_W-1:0] dat [STAGES];
    logic [STAGES:0]   prv_vld;
    logic [STAGES:0]   prv_mode;
    logic [DATA_W-1:0] prv_dat [STAGES+1];
    logic              full;
    logic              acc;
    logic              leave;

    // rotate every word by R bits; shifting by the full word width yields zero, so SHIFT=0 passes through
    always_comb begin
        shuf = '0;
        w    = '0;
        for (int k = 0; k < NW; k++) begin
            w = data_word(k);
            shuf[k*WORD_W +: WORD_W] = src.inv ? ((w >> R) | (w << (WORD_W - R)))
                                               : ((w << R) | (w >> (WORD_W - R)));
        end
    end

    function automatic logic [WORD_W-1:0] data_word(input int k);
        return src.data[k*WORD_W +: WORD_W];
    endfunction

    // a stage loads when the downstream accepts or any stage from here to the output is empty
    always_comb begin
        full = 1'b1;
        ld   = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            full  = full & vld[s];
            ld[s] = dst.ready | ~full;
        end
    end

    // source of each stage; input data is zeroed when not valid so idle slots never carry junk
    always_comb begin
        prv_vld[0]  = src.valid;
        prv_mode[0] = src.valid & src.inv;
        prv_dat[0]  = src.valid ? shuf : '0;
        for (int s = 0; s < STAGES; s++) begin
            prv_vld[s+1]  = vld[s];
            prv_mode[s+1] = mode[s];
            prv_dat[s+1]  = dat[s];
        end
    end

    // stage registers advance independently, squeezing out bubbles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld  <= '0;
            mode <= '0;
            for (int s = 0; s < STAGES; s++) dat[s] <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (ld[s]) begin
                    vld[s]  <= prv_vld[s];
                    mode[s] <= prv_mode[s];
                    dat[s]  <= prv_dat[s];
                end
            end
        end
    end

    assign acc   = src.valid & ld[0];
    assign leave = vld[STAGES-1] & dst.ready;

    // occupancy tracks accepts minus departures
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_o <= '0;
        else         count_o <= count_o + CW'(acc) - CW'(leave);
    end

    assign src.ready = ld[0];
    assign dst.valid = vld[STAGES-1];
    assign dst.data  = dat[STAGES-1];
    assign dst.inv   = mode[STAGES-1];
endmodule
